// File: rtl/conv3x3_stream.sv
// Streaming 3x3 convolution: NUM_K runtime-loaded kernels over a row-major pixel stream.
// Latency 1 from the window-completing pixel; single-entry output register gates pix_ready.
module conv3x3_stream #(
   parameter int IMG_W = 8,
   parameter int IMG_H = 8,
   parameter int NUM_K = 3,
   parameter int DW    = 8,
   parameter int ACC_W = 20,
   parameter int SHIFT = 8,
   parameter int OUT_W = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   wt_valid,
   output logic                   wt_ready,
   input  logic [DW-1:0]          wt_data,
   input  logic                   pix_valid,
   output logic                   pix_ready,
   input  logic [DW-1:0]          pix_data,
   input  logic                   relu_en,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [NUM_K*OUT_W-1:0] out_data,
   output logic                   out_last,
   output logic                   busy
);
   localparam int NW  = 9 * NUM_K;
   localparam int WIW = $clog2(NW);
   localparam int CW  = $clog2(IMG_W);
   localparam int RW  = $clog2(IMG_H);
   localparam logic signed [ACC_W-1:0] OMAX = ACC_W'(2 ** (OUT_W - 1) - 1);
   localparam logic signed [ACC_W-1:0] OMIN = ~OMAX;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} state_t;

   state_t                   state_q, state_d;
   logic signed [DW-1:0]     wt_q  [NW];
   logic [WIW-1:0]           widx_q;
   logic                     weights_ok_q, relu_q;
   logic [RW-1:0]            row_q;
   logic [CW-1:0]            col_q;
   logic signed [DW-1:0]     lb0_q [IMG_W];
   logic signed [DW-1:0]     lb1_q [IMG_W];
   logic signed [DW-1:0]     win_q [3][3];
   logic signed [DW-1:0]     win_d [3][3];
   logic                     out_valid_q, out_last_q;
   logic [NUM_K*OUT_W-1:0]   out_data_q, res_d;
   logic signed [2*DW-1:0]   prod;
   logic signed [ACC_W-1:0]  acc, v;
   logic                     wt_acc, pix_acc, out_free, frame_end, win_done;

   assign out_free  = !out_valid_q || out_ready;
   assign wt_acc    = wt_valid && wt_ready;
   assign pix_acc   = pix_valid && pix_ready;
   assign frame_end = (row_q == RW'(IMG_H - 1)) && (col_q == CW'(IMG_W - 1));
   assign win_done  = (row_q >= RW'(2)) && (col_q >= CW'(2));
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   // Weights take priority over pixels in idle so a reload is never split by a frame.
   always_comb begin
      state_d   = state_q;
      wt_ready  = 1'b0;
      pix_ready = 1'b0;
      case (state_q)
         S_IDLE: begin
            wt_ready  = 1'b1;
            pix_ready = weights_ok_q && !wt_valid && out_free;
            if (wt_valid)                    state_d = S_LOAD;
            else if (pix_valid && pix_ready) state_d = S_RUN;
         end
         S_LOAD: begin
            wt_ready = 1'b1;
            if (wt_valid && widx_q == WIW'(NW - 1)) state_d = S_IDLE;
         end
         S_RUN: begin
            pix_ready = out_free;
            if (pix_valid && out_free && frame_end) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NW; i++) wt_q[i] <= '0;
         widx_q       <= '0;
         weights_ok_q <= 1'b0;
      end else if (wt_acc) begin
         wt_q[widx_q] <= wt_data;
         if (widx_q == WIW'(NW - 1)) begin
            widx_q       <= '0;
            weights_ok_q <= 1'b1;
         end else begin
            widx_q       <= widx_q + WIW'(1);
            weights_ok_q <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q       <= '0;
         col_q       <= '0;
         relu_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
      end else begin
         if (pix_acc) begin
            if (state_q == S_IDLE) relu_q <= relu_en;
            if (col_q == CW'(IMG_W - 1)) begin
               col_q <= '0;
               row_q <= (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
               col_q <= col_q + CW'(1);
            end
         end
         if (pix_acc && win_done) begin
            out_valid_q <= 1'b1;
            out_data_q  <= res_d;
            out_last_q  <= frame_end;
         end else if (out_ready) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
      end
   end

   // Line buffers hold the two previous rows at the current column; the window shifts left.
   always_ff @(posedge clk) begin
      if (pix_acc) begin
         lb0_q[col_q] <= lb1_q[col_q];
         lb1_q[col_q] <= pix_data;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
               win_q[r][c] <= win_d[r][c];
      end
   end

   always_comb begin
      for (int r = 0; r < 3; r++) begin
         win_d[r][0] = win_q[r][1];
         win_d[r][1] = win_q[r][2];
      end
      win_d[0][2] = lb0_q[col_q];
      win_d[1][2] = lb1_q[col_q];
      win_d[2][2] = pix_data;
   end

   always_comb begin
      res_d = '0;
      prod  = '0;
      acc   = '0;
      v     = '0;
      for (int k = 0; k < NUM_K; k++) begin
         acc = '0;
         for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
               prod = win_d[r][c] * wt_q[k*9 + r*3 + c];
               acc  = acc + ACC_W'(prod);
            end
         v = acc >>> SHIFT;
         if (v > OMAX)      v = OMAX;
         else if (v < OMIN) v = OMIN;
         if (relu_q && v < 0) v = '0;
         res_d[k*OUT_W +: OUT_W] = v[OUT_W-1:0];
      end
   end
endmodule

// File: doc/conv3x3_stream.md
Name: conv3x3_stream

Overview:
- Streaming, parametrised successor to the combinational 8x8x1 / three-kernel 3x3 convolution.
- Accepts one signed pixel per handshake in row-major order and keeps two line buffers plus a 3x3 window.
- Applies NUM_K runtime-loadable 3x3 kernels and emits one output beat per valid window position, carrying all NUM_K channels.
- Adds handshake backpressure, serial weight loading, arbitrary image size and optional per-frame ReLU.

Parameters:
IMG_W, 8, image width in pixels (>=3)
IMG_H, 8, image height in pixels (>=3)
NUM_K, 3, number of kernels / output channels
DW, 8, signed pixel and weight width
ACC_W, 20, signed accumulator width; must be >= 2*DW+4
SHIFT, 8, arithmetic right shift applied to the sum before saturation
OUT_W, 8, signed output width per channel

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
wt_valid  in  1  weight word valid
wt_ready  out  1  weight word accepted when wt_valid && wt_ready
wt_data  in  DW  signed weight; word index k*9 + kr*3 + kc
pix_valid  in  1  pixel valid
pix_ready  out  1  pixel accepted when pix_valid && pix_ready
pix_data  in  DW  signed pixel, row-major (r*IMG_W + c)
relu_en  in  1  ReLU mode, sampled on the first pixel of a frame
out_valid  out  1  output beat valid
out_ready  in  1  downstream accept
out_data  out  NUM_K*OUT_W  channel k in bits [k*OUT_W +: OUT_W]
out_last  out  1  marks the final beat of a frame
busy  out  1  high in S_LOAD or S_RUN

Behaviour:
- Reset (asynchronous): state S_IDLE.
  - All weight registers 0; weights_ok 0; row/col counters 0.
  - Outputs: out_valid 0, out_data 0, out_last 0, busy 0, wt_ready 1, pix_ready 0.
- States:
  - S_IDLE: wt_ready=1. pix_ready = weights_ok && !wt_valid && (!out_valid || out_ready).
    - A weight accept stores word 0 and goes to S_LOAD; weights_ok is cleared.
    - A pixel accept stores pixel (0,0), latches relu_en and goes to S_RUN.
    - wt_valid and pix_valid together: weights win and no pixel is taken.
  - S_LOAD: wt_ready=1, pix_ready=0. One word is stored per accept.
    - After word 9*NUM_K-1: weights_ok=1, go to S_IDLE.
    - Gaps in wt_valid are allowed.
  - S_RUN: wt_ready=0, pix_ready = !out_valid || out_ready.
    - The column counter wraps at IMG_W-1 and increments the row counter.
    - Accepting pixel (IMG_H-1, IMG_W-1) returns to S_IDLE with counters cleared. Weights are retained, so a new frame may follow immediately.
- Window:
  - Accepting pixel (r,c) with r>=2 and c>=2 completes the window whose top-left is (r-2, c-2).
  - Window element (kr,kc) = pixel (r-2+kr, c-2+kc).
  - Edge columns do not wrap: windows with c<2 are never produced.
- Arithmetic, per channel:
  - sum = Σ sign-extended DW×DW products over the 9 window taps, in ACC_W bits.
  - v = sum >>> SHIFT (arithmetic shift, floor).
  - Saturate v to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - If the frame's latched relu is set, negative results become 0.
- Latency and output handshake:
  - out_data / out_valid register on the cycle after the completing pixel is accepted (latency 1).
  - out_valid and out_data hold stable until out_ready; the output is a single-entry register.
  - Pixel acceptance is gated as above, so no beat is ever dropped or overwritten.
  - Back-to-back streaming with out_ready=1 sustains 1 pixel/cycle.
- Frame framing:
  - (IMG_H-2)*(IMG_W-2) beats per frame, in row-major order of top-left position.
  - out_last=1 on the beat for (IMG_H-3, IMG_W-3).
  - The last beat may still be pending in S_IDLE; a new-frame pixel is accepted only when the output register is free or draining this cycle.
- Reset mid-frame or mid-load:
  - Immediate return to the reset values; the partial frame is discarded.
  - weights_ok=0, so pix_ready stays 0 until a full weight reload.

Test Plan:
- Reset then load 27 words (kernel0 all 64, kernel1 all -1, kernel2 center 127 and others 0), stream an 8x8 frame of 64s with out_ready=1, relu_en=0.
  - Required: 36 beats starting 1 cycle after pixel (2,2).
  - Per beat: ch0=127 (36864>>8=144, saturated), ch1=0xFD (-576>>8=-3), ch2=31 (8128>>8).
  - out_last on beat 36 only.
- Repeat the same frame with relu_en=1 sampled at frame start → ch1=0; ch0 and ch2 unchanged. Toggle relu_en mid-frame → no effect until the next frame.
- Extremes: pixels all -128, kernel0 all 127 → sum -146304, shift gives -572, saturated to 0x80 on every beat. No accumulator overflow.
- Ramp image pixel=r*8+c, kernel0 = identity at tap (0,0) with value 1<<SHIFT clipped to 127 (SHIFT set to 0 in this config) → beat (r,c) equals pixel (r,c). Checks window alignment and that no column wraps.
- Backpressure: hold out_ready=0 for 5 cycles mid-frame.
  - Required: pix_ready=0 while out_valid=1; out_data stable for the whole hold.
  - No beats lost: total still 36, contents identical to the unstalled run.
- Assert wt_valid and pix_valid together in S_IDLE → weight accepted, pixel stalled. Assert rst during pixel 20 → outputs clear; pix_ready stays 0 until 27 new words are loaded.
